// File: rtl/nds_sync_pkg.sv
// Shared constants and helpers for the nds level-synchronizer family.
package nds_sync_pkg;

  localparam int unsigned NDS_SYNC_STAGES_MIN = 2;
  localparam int unsigned NDS_SYNC_STAGES_MAX = 4;
  localparam int unsigned NDS_FILTER_LEN_MAX  = 256;

  // Filter counter width: clog2(len), never narrower than one bit.
  function automatic int unsigned nds_cnt_w(input int unsigned len);
    int unsigned w;
    w = (len > 1) ? $clog2(len) : 1;
    return w;
  endfunction

endpackage

// File: rtl/nds_sync_l2l_filt_ch.sv
// One channel: sync chain, stable-time filter, edge pulses and sticky edge flags.
module nds_sync_l2l_filt_ch
  import nds_sync_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 1,
  parameter logic        RESET_VALUE = 1'b0
) (
  input  logic b_clk,
  input  logic b_reset,
  input  logic a_signal,
  input  logic b_event_clr,
  output logic b_signal,
  output logic b_signal_rising_edge_pulse,
  output logic b_signal_falling_edge_pulse,
  output logic b_signal_edge_pulse,
  output logic b_event_rise,
  output logic b_event_fall
);

  localparam int unsigned SW    = SYNC_STAGES - 1;
  localparam int unsigned CNT_W = nds_cnt_w(FILTER_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic [SW-1:0]    s_q, s_d;
  logic             s_last;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             b_signal_q, b_signal_d;
  logic             d1_q;
  logic             rise, fall;
  logic             event_rise_q, event_rise_d;
  logic             event_fall_q, event_fall_d;

  // s_q[0] is the only flop that samples the asynchronous input.
  always_comb begin
    s_d    = s_q << 1;
    s_d[0] = a_signal;
  end

  assign s_last = s_q[SW-1];

  // Any return to agreement restarts the stable-time count from zero.
  always_comb begin
    b_signal_d = b_signal_q;
    cnt_d      = '0;
    if (s_last != b_signal_q) begin
      if (cnt_q == CNT_LAST) begin
        b_signal_d = s_last;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign rise = b_signal_q & ~d1_q;
  assign fall = ~b_signal_q & d1_q;

  // Set beats a simultaneous clear.
  always_comb begin
    event_rise_d = rise | (event_rise_q & ~b_event_clr);
    event_fall_d = fall | (event_fall_q & ~b_event_clr);
  end

  always_ff @(posedge b_clk) begin
    if (b_reset) begin
      s_q          <= {SW{RESET_VALUE}};
      cnt_q        <= '0;
      b_signal_q   <= RESET_VALUE;
      d1_q         <= RESET_VALUE;
      event_rise_q <= 1'b0;
      event_fall_q <= 1'b0;
    end else begin
      s_q          <= s_d;
      cnt_q        <= cnt_d;
      b_signal_q   <= b_signal_d;
      d1_q         <= b_signal_q;
      event_rise_q <= event_rise_d;
      event_fall_q <= event_fall_d;
    end
  end

  assign b_signal                    = b_signal_q;
  assign b_signal_rising_edge_pulse  = rise;
  assign b_signal_falling_edge_pulse = fall;
  assign b_signal_edge_pulse         = b_signal_q ^ d1_q;
  assign b_event_rise                = event_rise_q;
  assign b_event_fall                = event_fall_q;

endmodule

// File: rtl/nds_sync_l2l_filt.sv
// Multi-channel filtered level synchronizer with edge pulses and sticky edge status.
module nds_sync_l2l_filt
  import nds_sync_pkg::*;
#(
  parameter int unsigned       NUM_CH      = 4,
  parameter int unsigned       SYNC_STAGES = 2,
  parameter int unsigned       FILTER_LEN  = 1,
  parameter logic [NUM_CH-1:0] RESET_VALUE = {NUM_CH{1'b0}}
) (
  input  logic              b_clk,
  input  logic              b_reset,
  input  logic [NUM_CH-1:0] a_signal,
  input  logic [NUM_CH-1:0] b_event_clr,
  output logic [NUM_CH-1:0] b_signal,
  output logic [NUM_CH-1:0] b_signal_rising_edge_pulse,
  output logic [NUM_CH-1:0] b_signal_falling_edge_pulse,
  output logic [NUM_CH-1:0] b_signal_edge_pulse,
  output logic [NUM_CH-1:0] b_event_rise,
  output logic [NUM_CH-1:0] b_event_fall,
  output logic              b_event_any
);

  if (NUM_CH < 1 || NUM_CH > 32) begin : gen_bad_num_ch
    $error("nds_sync_l2l_filt: NUM_CH must be in 1..32");
  end
  if (SYNC_STAGES < NDS_SYNC_STAGES_MIN || SYNC_STAGES > NDS_SYNC_STAGES_MAX) begin : gen_bad_sync
    $error("nds_sync_l2l_filt: SYNC_STAGES must be in 2..4");
  end
  if (FILTER_LEN < 1 || FILTER_LEN > NDS_FILTER_LEN_MAX) begin : gen_bad_filt
    $error("nds_sync_l2l_filt: FILTER_LEN must be in 1..256");
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : gen_ch
    nds_sync_l2l_filt_ch #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILTER_LEN (FILTER_LEN),
      .RESET_VALUE(RESET_VALUE[i])
    ) u_ch (
      .b_clk                      (b_clk),
      .b_reset                    (b_reset),
      .a_signal                   (a_signal[i]),
      .b_event_clr                (b_event_clr[i]),
      .b_signal                   (b_signal[i]),
      .b_signal_rising_edge_pulse (b_signal_rising_edge_pulse[i]),
      .b_signal_falling_edge_pulse(b_signal_falling_edge_pulse[i]),
      .b_signal_edge_pulse        (b_signal_edge_pulse[i]),
      .b_event_rise               (b_event_rise[i]),
      .b_event_fall               (b_event_fall[i])
    );
  end

  assign b_event_any = |{b_event_rise, b_event_fall};

endmodule

// File: tb/tb_nds_sync_l2l_filt.sv
// Directed and scoreboard-checked bench for nds_sync_l2l_filt across three configurations.
module tb_nds_sync_l2l_filt;

  localparam int unsigned SC = 3;
  localparam int unsigned FC = 8;
  localparam logic [7:0]  RV_C = 8'hA5;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dut_a: defaults, RESET_VALUE=4'b1010
  logic       rst_a;
  logic [3:0] a_a, clr_a, b_a, rise_a, fall_a, edge_a, er_a, ef_a;
  logic       any_a;
  // dut_b: one channel, SYNC_STAGES=3, FILTER_LEN=4
  logic       rst_b, a_b, clr_b, b_b, rise_b, fall_b, edge_b, er_b, ef_b, any_b;
  // dut_c: eight channels, SYNC_STAGES=3, FILTER_LEN=8
  logic       rst_c;
  logic [7:0] a_c, clr_c, b_c, rise_c, fall_c, edge_c, er_c, ef_c;
  logic       any_c;

  nds_sync_l2l_filt #(
    .NUM_CH(4), .SYNC_STAGES(2), .FILTER_LEN(1), .RESET_VALUE(4'b1010)
  ) dut_a (
    .b_clk(clk), .b_reset(rst_a), .a_signal(a_a), .b_event_clr(clr_a),
    .b_signal(b_a), .b_signal_rising_edge_pulse(rise_a),
    .b_signal_falling_edge_pulse(fall_a), .b_signal_edge_pulse(edge_a),
    .b_event_rise(er_a), .b_event_fall(ef_a), .b_event_any(any_a)
  );

  nds_sync_l2l_filt #(
    .NUM_CH(1), .SYNC_STAGES(3), .FILTER_LEN(4), .RESET_VALUE(1'b0)
  ) dut_b (
    .b_clk(clk), .b_reset(rst_b), .a_signal(a_b), .b_event_clr(clr_b),
    .b_signal(b_b), .b_signal_rising_edge_pulse(rise_b),
    .b_signal_falling_edge_pulse(fall_b), .b_signal_edge_pulse(edge_b),
    .b_event_rise(er_b), .b_event_fall(ef_b), .b_event_any(any_b)
  );

  nds_sync_l2l_filt #(
    .NUM_CH(8), .SYNC_STAGES(SC), .FILTER_LEN(FC), .RESET_VALUE(RV_C)
  ) dut_c (
    .b_clk(clk), .b_reset(rst_c), .a_signal(a_c), .b_event_clr(clr_c),
    .b_signal(b_c), .b_signal_rising_edge_pulse(rise_c),
    .b_signal_falling_edge_pulse(fall_c), .b_signal_edge_pulse(edge_c),
    .b_event_rise(er_c), .b_event_fall(ef_c), .b_event_any(any_c)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model for dut_c: expected outputs after the next edge.
  typedef struct packed {
    logic [7:0] b, rise, fall, er, ef;
    logic       any;
  } exp_c_t;

  exp_c_t     sb_q[$];
  logic [7:0] m_s0, m_s1, m_b, m_d1, m_er, m_ef;
  int         m_run[8];

  task automatic model_c(input logic [7:0] a, input logic [7:0] clr, input logic rst);
    logic [7:0] r, f;
    if (rst) begin
      m_s0 = RV_C; m_s1 = RV_C; m_b = RV_C; m_d1 = RV_C; m_er = '0; m_ef = '0;
      for (int ch = 0; ch < 8; ch++) m_run[ch] = 0;
    end else begin
      r    = m_b & ~m_d1;
      f    = ~m_b & m_d1;
      m_er = r | (m_er & ~clr);
      m_ef = f | (m_ef & ~clr);
      m_d1 = m_b;
      for (int ch = 0; ch < 8; ch++) begin
        if (m_s1[ch] != m_b[ch]) begin
          m_run[ch]++;
          if (m_run[ch] >= FC) begin
            m_b[ch]   = m_s1[ch];
            m_run[ch] = 0;
          end
        end else begin
          m_run[ch] = 0;
        end
      end
      m_s1 = m_s0;
      m_s0 = a;
    end
  endtask

  task automatic cycle_c(input logic [7:0] a, input logic [7:0] clr, input logic rst);
    exp_c_t e;
    a_c = a; clr_c = clr; rst_c = rst;
    model_c(a, clr, rst);
    e.b = m_b; e.rise = m_b & ~m_d1; e.fall = ~m_b & m_d1;
    e.er = m_er; e.ef = m_ef; e.any = |{m_er, m_ef};
    sb_q.push_back(e);
    tick();
    e = sb_q.pop_front();
    check("c_b",    32'(b_c),    32'(e.b));
    check("c_rise", 32'(rise_c), 32'(e.rise));
    check("c_fall", 32'(fall_c), 32'(e.fall));
    check("c_er",   32'(er_c),   32'(e.er));
    check("c_ef",   32'(ef_c),   32'(e.ef));
    check("c_any",  32'(any_c),  32'(e.any));
  endtask

  logic [7:0] a_cur, flip;

  initial begin
    rst_a = 1'b1; a_a = 4'b1010; clr_a = '0;
    rst_b = 1'b1; a_b = 1'b0;    clr_b = 1'b0;
    rst_c = 1'b1; a_c = RV_C;    clr_c = '0;

    // ---- dut_a: reset level, latency, sticky set-vs-clear
    repeat (3) tick();
    check("a_rst_b",    32'(b_a),    32'(4'b1010));
    check("a_rst_edge", 32'(edge_a), 32'(0));
    check("a_rst_any",  32'(any_a),  32'(0));
    rst_a = 1'b0; rst_b = 1'b0;
    tick();
    check("a_post_b",     32'(b_a),              32'(4'b1010));
    check("a_post_pulse", 32'({rise_a, fall_a}), 32'(0));
    check("a_post_any",   32'(any_a),            32'(0));
    tick();

    a_a[0] = 1'b1;
    tick();
    check("a_lat_e0_b",  32'(b_a[0]), 32'(0));
    tick();
    check("a_lat_e1_b",  32'(b_a[0]), 32'(1));
    check("a_lat_rise",  32'(rise_a), 32'(4'b0001));
    check("a_lat_edge",  32'(edge_a), 32'(4'b0001));
    check("a_lat_er_e1", 32'(er_a),   32'(0));
    tick();
    check("a_lat_rise_e2", 32'(rise_a), 32'(0));
    check("a_lat_er_e2",   32'(er_a),   32'(4'b0001));
    check("a_lat_any_e2",  32'(any_a),  32'(1));
    clr_a = 4'b0001;
    tick();
    clr_a = '0;
    check("a_clr0_er",  32'(er_a),  32'(0));
    check("a_clr0_any", 32'(any_a), 32'(0));

    a_a[2] = 1'b1;
    tick();
    tick();
    check("a_ch2_rise", 32'(rise_a), 32'(4'b0100));
    clr_a = 4'b0100;
    tick();
    check("a_setwins_er", 32'(er_a),   32'(4'b0100));
    check("a_setwins_rp", 32'(rise_a), 32'(0));
    tick();
    clr_a = '0;
    check("a_clr2_er", 32'(er_a), 32'(0));

    a_a[3] = 1'b0;
    tick();
    tick();
    check("a_ch3_fall", 32'(fall_a), 32'(4'b1000));
    check("a_ch3_edge", 32'(edge_a), 32'(4'b1000));
    tick();
    check("a_ch3_ef",  32'(ef_a),  32'(4'b1000));
    check("a_ch3_any", 32'(any_a), 32'(1));

    // ---- dut_b: 3-cycle glitch rejected, 4-cycle level accepted at edge 5
    a_b = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 2) a_b = 1'b0;
      check("b_glitch_b",    32'(b_b),    32'(0));
      check("b_glitch_edge", 32'(edge_b), 32'(0));
    end
    a_b = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 3) a_b = 1'b0;
      check("b_acc_b",    32'(b_b),    32'(i >= 5 && i <= 8));
      check("b_acc_rise", 32'(rise_b), 32'(i == 5));
      check("b_acc_fall", 32'(fall_b), 32'(i == 9));
    end

    // ---- dut_c: mid-filter reset, random independence, reset from opposite level
    repeat (3) cycle_c(RV_C, 8'h00, 1'b1);
    repeat (3) cycle_c(RV_C, 8'h00, 1'b0);
    repeat (4) cycle_c(RV_C | 8'h02, 8'h00, 1'b0);
    cycle_c(RV_C | 8'h02, 8'h00, 1'b1);
    check("c_midrst_b1",   32'(b_c[1]),    32'(RV_C[1]));
    check("c_midrst_edge", 32'(edge_c[1]), 32'(0));
    repeat (14) cycle_c(RV_C | 8'h02, 8'h00, 1'b0);

    a_cur = RV_C | 8'h02;
    for (int n = 0; n < 400; n++) begin
      flip = '0;
      for (int ch = 0; ch < 8; ch++) flip[ch] = ($urandom_range(0, 11) == 0);
      a_cur = a_cur ^ flip;
      cycle_c(a_cur, 8'($urandom & $urandom & $urandom), 1'b0);
    end

    repeat (20) cycle_c(~RV_C, 8'h00, 1'b0);
    cycle_c(~RV_C, 8'h00, 1'b1);
    check("c_oppo_rst_b",    32'(b_c),    32'(RV_C));
    check("c_oppo_rst_edge", 32'(edge_c), 32'(0));
    repeat (5) cycle_c(~RV_C, 8'h00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/nds_sync_l2l_filt.md
# nds_sync_l2l_filt

Multi-channel level synchronizer with per-channel glitch filter, edge detection and sticky edge status. It brings NUM_CH asynchronous level signals (e.g. external DMA request lines, interrupt levels) into the b_clk domain. It qualifies each level with a programmable stable-time filter, then provides per-channel rise/fall/any-edge pulses plus sticky event flags that software-facing logic clears. This is the parametrised successor of the two-flop level synchronizer: configurable width, sync depth and per-channel reset value, plus filtering and event capture.

## Interface
Parameters:
- NUM_CH, 4, number of independent channels (1..32)
- SYNC_STAGES, 2, total flops from a_signal to b_signal, including b_signal itself (2..4)
- FILTER_LEN, 1, cycles s_last must differ from b_signal before b_signal follows; 1 means no filtering (1..256)
- RESET_VALUE, {NUM_CH{1'b0}}, per-channel reset level of every sync, b_signal and d1 flop

Ports (one clock; reset is synchronous and active-high):
- b_clk  input  1  destination clock; all flops are posedge
- b_reset  input  1  synchronous, active-high reset
- a_signal  input  NUM_CH  asynchronous levels
- b_event_clr  input  NUM_CH  per-channel clear pulse for the sticky flags
- b_signal  output  NUM_CH  synchronized, filtered level
- b_signal_rising_edge_pulse  output  NUM_CH  1-cycle pulse on a 0->1 transition of b_signal
- b_signal_falling_edge_pulse  output  NUM_CH  1-cycle pulse on a 1->0 transition of b_signal
- b_signal_edge_pulse  output  NUM_CH  OR of rise and fall
- b_event_rise  output  NUM_CH  sticky rise flag
- b_event_fall  output  NUM_CH  sticky fall flag
- b_event_any  output  1  OR of all sticky flags

## Operation
- Per channel, the sync chain is s[0..SYNC_STAGES-2], with s[0] <= a_signal and s_last = s[SYNC_STAGES-2].
- The filter counter cnt is clog2(FILTER_LEN) bits wide, minimum 1. Each cycle:
  - if s_last == b_signal: cnt <= 0
  - else if cnt == FILTER_LEN-1: b_signal <= s_last and cnt <= 0
  - else: cnt <= cnt+1
- With FILTER_LEN=1, b_signal <= s_last every cycle.
- A mismatch shorter than FILTER_LEN consecutive cycles never reaches b_signal. The counter restarts on every return to agreement; there is no partial credit.
- b_signal_d1 <= b_signal.
- Edge pulses are combinational from b_signal and b_signal_d1:
  - rise = b_signal & ~d1
  - fall = ~b_signal & d1
  - edge = b_signal ^ d1
- Sticky flags:
  - b_event_rise[i] <= rise[i] | (b_event_rise[i] & ~b_event_clr[i])
  - b_event_fall[i] is the same, using fall[i]
  - When set and clear occur in the same cycle, set wins.
- b_event_any is combinational: the OR of all b_event_rise and b_event_fall bits.
- Channels are fully independent; nothing is shared except b_event_any.

## Timing
- Reset values:
  - s[*], b_signal and b_signal_d1 = RESET_VALUE[i]
  - cnt = 0
  - sticky flags = 0
  - Therefore all pulses and b_event_any are 0 during reset and in the first cycle after it.
- Latency:
  - When a_signal changes before edge k and is held, b_signal changes at edge k+SYNC_STAGES+FILTER_LEN-2.
  - The edge pulse is high in the cycle that follows that edge.
  - The sticky flag is high one edge later.
- Default parameters give 2-edge latency, which matches the legacy synchronizer.
- Pulse width is exactly 1 cycle per b_signal transition. The minimum spacing between b_signal transitions is FILTER_LEN cycles.
- b_event_clr takes effect at the next edge; the flag reads 0 in the following cycle unless a new edge occurs.
- Reset asserted mid-filter: cnt returns to 0 and b_signal returns to RESET_VALUE. No pulse is generated by the reset itself, even if b_signal was at the opposite level.
- a_signal meta/X handling is the responsibility of the s[0] flop only. No logic other than s[0] samples a_signal.

## Structure
- Shared package nds_sync_pkg holds:
  - NDS_SYNC_STAGES_MIN=2 and NDS_SYNC_STAGES_MAX=4
  - NDS_FILTER_LEN_MAX=256
  - function nds_cnt_w(len), returning max(1, clog2(len))
- Sub-module nds_sync_l2l_filt_ch implements one channel: sync chain, filter, d1, pulses and sticky flags. It takes a scalar RESET_VALUE and is instantiated NUM_CH times via generate.
- The top level adds only the parameter-range checks (elaboration-time error) and the b_event_any reduction.

## Test plan
- Reset-level check: RESET_VALUE=4'b1010, with a_signal held at 4'b1010 through reset release -> b_signal=4'b1010, no pulses, b_event_any=0.
- Latency (defaults): a_signal[0] set 0->1 before edge 0 -> b_signal[0]=1 after edge 1; rise pulse high for exactly 1 cycle; b_event_rise[0]=1 after edge 2.
- Glitch reject (FILTER_LEN=4, SYNC_STAGES=3): 3-cycle high glitch at s_last -> b_signal stays 0 and no pulse. A 4-cycle high -> b_signal=1 at edge 3+4-2=5 after the change.
- Sticky set-vs-clear: assert b_event_clr[2] in the same cycle as rise[2] -> b_event_rise[2] stays 1. Assert clr alone in the next cycle -> reads 0 after 1 edge.
- Mid-filter reset: a_signal[1]=1 held for 2 of FILTER_LEN=8 cycles, then b_reset pulses -> cnt=0 and b_signal[1]=RESET_VALUE[1], no fall or rise pulse.
- Channel independence (NUM_CH=8, random toggles per channel): each channel's b_signal matches a reference model with per-channel latency; b_event_any equals the OR of the sticky flags every cycle.
